fetcher_iq: RTL and testbench

Parametrised next-generation instruction fetch unit. It holds the PC and issues icache reads. It queries the branch predictor on each hit and pushes predicted instructions into an internal instruction queue. Decode drains the queue through a valid/ready handshake, which decouples fetch from decode stalls. The block sits between the icache/bp and the decode unit, and takes rollback from the ROB.

---
 rtl/fetcher_iq_pkg.sv | 20 ++
 rtl/fetcher_iq_inst_queue.sv | 60 ++++++
 rtl/fetcher_iq.sv | 97 +++++++++
 tb/tb_fetcher_iq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetcher_iq_pkg.sv
// Shared fetch-side types and constants.
// Default widths, PC step and packed queue-entry width helper.
package fetcher_iq_pkg;

    localparam int ADDR_TP = 32;
    localparam int WORD_TP = 32;
    localparam int NEXT_PC_INC = 4;

    localparam logic [ADDR_TP-1:0] ZERO_ADDR = '0;

    localparam logic TRUE = 1'b1;
    localparam logic FALSE = 1'b0;

    function automatic int iq_entry_w(input int inst_w, input int addr_w);
        return inst_w + 2 * addr_w + 1;
    endfunction

    localparam int IQ_ENTRY_W = iq_entry_w(WORD_TP, ADDR_TP);

endpackage

// File: rtl/fetcher_iq_inst_queue.sv
// Synchronous show-ahead FIFO with flush.
// DEPTH must be a power of two so pointers wrap naturally.
module inst_queue
    import fetcher_iq_pkg::*;
#(
    parameter int W = IQ_ENTRY_W,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Reads are masked to zero so an empty queue never exposes stale data.
    assign rdata = empty ? '0 : mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                tail <= tail + PTR_W'(1);
            if (do_pop)
                head <= head + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push)
            mem[tail] <= wdata;
    end

endmodule

// File: rtl/fetcher_iq.sv
// Instruction fetch: PC, predictor muxing and an instruction queue
// that decouples icache hits from decode stalls.
module fetcher_iq
    import fetcher_iq_pkg::*;
#(
    parameter int ADDR_W = ADDR_TP,
    parameter int INST_W = WORD_TP,
    parameter int IQ_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int PC_INC = NEXT_PC_INC,
    localparam int CNT_W = $clog2(IQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_en,
    input  logic              if_rb,
    input  logic [ADDR_W-1:0] rb_pc,
    output logic              cache_rd_en,
    output logic [ADDR_W-1:0] cache_rd_addr,
    input  logic              cache_hit,
    input  logic [INST_W-1:0] cache_hit_inst,
    output logic [ADDR_W-1:0] bp_pb_pc,
    output logic [INST_W-1:0] bp_pb_inst,
    input  logic              bp_pd_tk,
    input  logic [ADDR_W-1:0] bp_pd_off,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_cur_pc,
    output logic [ADDR_W-1:0] id_mis_pc,
    output logic              id_pd_tk,
    output logic [CNT_W-1:0]  iq_count
);

    localparam int EW = INST_W + 2 * ADDR_W + 1;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] succ;
    logic [ADDR_W-1:0] jump;
    logic [ADDR_W-1:0] mis;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              flush;
    logic [EW-1:0]     wdata;
    logic [EW-1:0]     rdata;

    assign succ = pc + ADDR_W'(PC_INC);
    assign jump = pc + bp_pd_off;
    assign mis  = bp_pd_tk ? succ : jump;

    assign cache_rd_en   = if_en & ~full & ~if_rb;
    assign cache_rd_addr = pc;
    assign bp_pb_pc      = pc;
    assign bp_pb_inst    = cache_hit_inst;

    // A zero word from the icache is a bubble and never enters the queue.
    assign push  = rdy & if_en & ~if_rb & ~full & cache_hit
                 & (cache_hit_inst != '0);
    assign pop   = rdy & ~empty & id_ready & ~if_rb;
    assign flush = rdy & if_rb;

    assign wdata = {cache_hit_inst, pc, mis, bp_pd_tk};

    inst_queue #(
        .W     (EW),
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (iq_count)
    );

    assign id_valid = ~empty;
    assign {id_inst, id_cur_pc, id_mis_pc, id_pd_tk} = rdata;

    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (rdy) begin
            if (if_rb)
                pc <= rb_pc;
            else if (push)
                pc <= bp_pd_tk ? jump : succ;
        end
    end

endmodule

// File: tb/tb_fetcher_iq.sv
// Self-checking bench for fetcher_iq: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_fetcher_iq;

    localparam int AW = 32;
    localparam int IW = 32;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          if_en;
    logic          if_rb;
    logic [AW-1:0] rb_pc;
    logic          cache_rd_en;
    logic [AW-1:0] cache_rd_addr;
    logic          cache_hit;
    logic [IW-1:0] cache_hit_inst;
    logic [AW-1:0] bp_pb_pc;
    logic [IW-1:0] bp_pb_inst;
    logic          bp_pd_tk;
    logic [AW-1:0] bp_pd_off;
    logic          id_ready;
    logic          id_valid;
    logic [IW-1:0] id_inst;
    logic [AW-1:0] id_cur_pc;
    logic [AW-1:0] id_mis_pc;
    logic          id_pd_tk;
    logic [3:0]    iq_count;

    always #5 clk = ~clk;

    fetcher_iq #(
        .ADDR_W   (AW),
        .INST_W   (IW),
        .IQ_DEPTH (D),
        .RESET_PC ('0),
        .PC_INC   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .if_en          (if_en),
        .if_rb          (if_rb),
        .rb_pc          (rb_pc),
        .cache_rd_en    (cache_rd_en),
        .cache_rd_addr  (cache_rd_addr),
        .cache_hit      (cache_hit),
        .cache_hit_inst (cache_hit_inst),
        .bp_pb_pc       (bp_pb_pc),
        .bp_pb_inst     (bp_pb_inst),
        .bp_pd_tk       (bp_pd_tk),
        .bp_pd_off      (bp_pd_off),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_cur_pc      (id_cur_pc),
        .id_mis_pc      (id_mis_pc),
        .id_pd_tk       (id_pd_tk),
        .iq_count       (iq_count)
    );

    typedef struct {
        logic [IW-1:0] inst;
        logic [AW-1:0] cur;
        logic [AW-1:0] mis;
        logic          tk;
    } ent_t;

    ent_t          mq[$];
    logic [AW-1:0] mpc;
    bit            mok = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare at the falling edge, then advance the model with the
    // inputs that the DUT will see at the next rising edge.
    task automatic cycle();
        ent_t h;
        ent_t e;
        bit   pu;
        bit   po;
        @(negedge clk);
        if (mok) begin
            h = '{default: '0};
            if (mq.size() > 0)
                h = mq[0];
            chk("cache_rd_en", cache_rd_en,
                if_en && mq.size() < D && !if_rb);
            chk("cache_rd_addr", cache_rd_addr, mpc);
            chk("bp_pb_pc", bp_pb_pc, mpc);
            chk("bp_pb_inst", bp_pb_inst, cache_hit_inst);
            chk("id_valid", id_valid, mq.size() > 0);
            chk("iq_count", iq_count, mq.size());
            chk("id_inst", id_inst, h.inst);
            chk("id_cur_pc", id_cur_pc, h.cur);
            chk("id_mis_pc", id_mis_pc, h.mis);
            chk("id_pd_tk", id_pd_tk, h.tk);
        end
        if (rst) begin
            mpc = '0;
            mq.delete();
            mok = 1;
        end else if (mok && rdy) begin
            if (if_rb) begin
                mq.delete();
                mpc = rb_pc;
            end else begin
                pu = if_en && mq.size() < D && cache_hit
                     && cache_hit_inst != 0;
                po = mq.size() > 0 && id_ready;
                if (po)
                    void'(mq.pop_front());
                if (pu) begin
                    e.inst = cache_hit_inst;
                    e.cur  = mpc;
                    e.mis  = bp_pd_tk ? mpc + 4 : mpc + bp_pd_off;
                    e.tk   = bp_pd_tk;
                    mq.push_back(e);
                    mpc = bp_pd_tk ? mpc + bp_pd_off : mpc + 4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rollback(input logic [AW-1:0] target);
        if_rb     = 1'b1;
        rb_pc     = target;
        cache_hit = 1'b0;
        cycle();
        if_rb = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        if_en = 1'b1;
        if_rb = 1'b0;
        rb_pc = '0;
        cache_hit = 1'b0;
        cache_hit_inst = '0;
        bp_pd_tk = 1'b0;
        bp_pd_off = 32'h40;
        id_ready = 1'b1;
        cycle();
        cycle();
        chk("reset_valid", id_valid, 0);
        chk("reset_count", iq_count, 0);
        chk("reset_pc", cache_rd_addr, 0);
        rst = 1'b0;

        // Three sequential hits with decode always ready.
        for (int i = 0; i < 3; i++) begin
            cache_hit = 1'b1;
            cache_hit_inst = 32'h13 + 32'h80 * i;
            if (i > 0)
                chk("seq_cur", id_cur_pc, (i - 1) * 4);
            cycle();
        end
        chk("seq_last_cur", id_cur_pc, 32'h8);
        chk("seq_last_mis", id_mis_pc, 32'h48);
        chk("seq_pc", cache_rd_addr, 32'hC);

        // Taken prediction.
        rollback(32'h10);
        id_ready = 1'b0;
        cache_hit = 1'b1;
        cache_hit_inst = 32'h6f;
        bp_pd_tk = 1'b1;
        bp_pd_off = 32'h20;
        cycle();
        chk("tk_cur", id_cur_pc, 32'h10);
        chk("tk_mis", id_mis_pc, 32'h14);
        chk("tk_flag", id_pd_tk, 1);
        chk("tk_pc", cache_rd_addr, 32'h30);
        bp_pd_tk = 1'b0;

        // Fill to full with decode stalled, then drain in order.
        rollback(32'h0);
        id_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cache_hit = 1'b1;
            cache_hit_inst = 32'h100 + i;
            cycle();
        end
        chk("full_count", iq_count, 8);
        chk("full_rd_en", cache_rd_en, 0);
        chk("full_pc", cache_rd_addr, 32'h20);
        cache_hit = 1'b0;
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_cur", id_cur_pc, i * 4);
            cycle();
        end
        chk("drain_empty", id_valid, 0);
        id_ready = 1'b0;
        cache_hit = 1'b1;
        cache_hit_inst = 32'h55;
        chk("resume_pc", cache_rd_addr, 32'h20);
        cycle();
        chk("resume_cur", id_cur_pc, 32'h20);

        // Rollback with five entries and a concurrent hit.
        rollback(32'h0);
        for (int i = 0; i < 5; i++) begin
            cache_hit = 1'b1;
            cache_hit_inst = 32'h200 + i;
            cycle();
        end
        chk("rb_pre_count", iq_count, 5);
        if_rb = 1'b1;
        rb_pc = 32'h100;
        cycle();
        if_rb = 1'b0;
        chk("rb_count", iq_count, 0);
        chk("rb_valid", id_valid, 0);
        chk("rb_pc", cache_rd_addr, 32'h100);

        // Steady push+pop at three entries across pointer wrap.
        rollback(32'h200);
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cache_hit = 1'b1;
            cache_hit_inst = 32'h300 + i;
            cycle();
        end
        chk("pp_pre_count", iq_count, 3);
        id_ready = 1'b1;
        for (int i = 0; i < 2 * D; i++) begin
            cache_hit_inst = 32'h400 + i;
            cycle();
            chk("pp_count", iq_count, 3);
        end

        // Global stall, then a bubble instruction.
        rdy = 1'b0;
        cache_hit_inst = 32'h33;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stall_count", iq_count, 3);
            chk("stall_pc", cache_rd_addr, 32'h24C);
        end
        rdy = 1'b1;
        id_ready = 1'b0;
        cache_hit_inst = '0;
        cycle();
        chk("bubble_count", iq_count, 3);
        chk("bubble_pc", cache_rd_addr, 32'h24C);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            if_en = ($urandom_range(0, 7) != 0);
            if_rb = ($urandom_range(0, 39) == 0);
            rb_pc = $urandom & 32'hFFFF_FFFC;
            cache_hit = ($urandom_range(0, 3) != 0);
            cache_hit_inst = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
            bp_pd_tk = $urandom_range(0, 1);
            bp_pd_off = $urandom;
            id_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
